rob_commit_controller: RTL
==========================

Name: rob_commit_controller

Overview:
- Circular reorder buffer that sequences in-order retirement into the register file.
- Allocates one entry per decoded instruction and publishes the allocated ID as rob_tail_id, which the register file stores as the destination's dependency.
- Marks entries complete from writeback, commits at most one completed head entry per cycle via rob_ready/rob_rd/rob_val/rob_head_id.
- On a committed mispredict, drains the commit, then issues a one-cycle global flush.

Parameters:
ROB_SIZE_WIDTH, 3, log2 of entry count (8 entries)
XLEN, 32, data/PC width
REG_CNT_WIDTH, 5, architectural register index width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
stall  in  1  global stall; blocks allocation
dec_ready  in  1  decoder presents an instruction
dec_rd  in  REG_CNT_WIDTH  destination register (0 = none: stores, branches)
dec_halt  in  1  instruction is HALT
wb_valid  in  1  writeback strobe
wb_id  in  ROB_SIZE_WIDTH  entry being completed
wb_val  in  XLEN  result value
wb_mispredict  in  1  entry redirects control flow
wb_pc  in  XLEN  correct next PC when wb_mispredict
rob_full  out  1  allocation impossible this cycle
rob_ready  out  1  commit strobe to register file (registered)
rob_rd  out  REG_CNT_WIDTH  committed destination
rob_val  out  XLEN  committed value
rob_head_id  out  ROB_SIZE_WIDTH  current head pointer
rob_tail_id  out  ROB_SIZE_WIDTH  ID given to an instruction allocated this cycle
flush  out  1  one-cycle pipeline flush
flush_pc  out  XLEN  redirect target, valid with flush
halted  out  1  sticky; HALT committed

Behaviour:
- Reset (async, rst_n=0): head=tail=count=0, all entry valid/ready cleared, state RUN; rob_ready, flush, halted = 0; rob_rd, rob_val, flush_pc = 0. Release mid-operation discards all entries.
- Entry fields: valid, ready, rd, val, mispredict, pc, halt.
- rob_tail_id = tail (combinational). rob_head_id = head (registered pointer).
- rob_full = (count == 2^ROB_SIZE_WIDTH) || state != RUN || halted.
- Allocate when dec_ready && !stall && !rob_full: entry[tail] <= {valid=1, ready=0, rd=dec_rd, halt=dec_halt}; tail <= tail+1 (mod wrap).
- Allocation attempted while rob_full: ignored, no state change.
- Writeback: if wb_valid && entry[wb_id].valid, set ready, val, mispredict, pc. Writeback to an invalid entry is ignored.
- Writeback to head in cycle N: head commits no earlier than N+1, since the ready flag must be registered first.
- Commit condition: state RUN && entry[head].valid && entry[head].ready.
- Commit actions at the edge ending cycle N:
  - rob_ready<=1; rob_rd<=entry.rd; rob_val<=entry.val.
  - entry invalid; head<=head+1.
  - Outputs in N+1 show rob_head_id already advanced, so the register file's "rob_head_id-1 == dependency" match identifies the committing entry.
- Otherwise rob_ready<=0.
- Simultaneous allocate and commit: count unchanged. Allocate into the slot freed by commit in the same cycle is legal only when count < max before the edge.
- HALT commit: halted<=1 (sticky until reset); no further allocation or commit.
- State machine (RUN, DRAIN, FLUSH):
  - RUN → DRAIN: a committing entry has mispredict=1. Its commit proceeds normally (rob_ready in DRAIN cycle), flush_pc<=entry.pc.
  - DRAIN → FLUSH: unconditional. No commit, no allocation. flush<=1 for the FLUSH cycle, so the rob_ready write precedes flush and is not lost by the register file.
  - FLUSH → RUN: all valid cleared, head=tail=count=0, flush<=0, rob_ready=0.
- Writebacks arriving during DRAIN/FLUSH are discarded.
- Pointer arithmetic: ROB_SIZE_WIDTH bits, natural wrap. count is ROB_SIZE_WIDTH+1 bits to distinguish full from empty.

Test Plan:
- Reset, allocate rd=5 (id 0), writeback id0 val=0x1234 → one cycle later rob_ready=1, rob_rd=5, rob_val=0x1234, rob_head_id=1; next cycle rob_ready=0.
- Allocate 8 with no writeback → rob_full=1 after 8th; 9th dec_ready ignored (tail stays 0); write back id0 → commit, rob_full drops, allocation lands in id0 (wrap).
- Writebacks out of order ids 2,1,0 → commits strictly in order 0,1,2 on consecutive cycles.
- Allocate ids 0–3; writeback id1 mispredict pc=0x80 plus id0 → commits 0, then 1 (rob_ready, DRAIN); next cycle flush=1, flush_pc=0x80, rob_ready=0; following cycle head=tail=0, rob_full=0, ids 2–3 gone.
- Allocate and commit in the same cycle at count=8 → allocation refused; at count=7 → accepted, count stays 7.
- rst_n low mid-flush (state DRAIN) → flush=0, rob_ready=0, pointers 0 immediately (async); HALT allocated, completed, committed → halted=1, rob_full=1 persistently.

Source files
------------

// File: rtl/rob_commit_controller.sv
// Reorder buffer that retires completed instructions in program order and
// turns a committed mispredict into a drain cycle followed by a one-cycle flush.
module rob_commit_controller #(
    parameter int ROB_SIZE_WIDTH = 3,
    parameter int XLEN           = 32,
    parameter int REG_CNT_WIDTH  = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      stall,
    input  logic                      dec_ready,
    input  logic [REG_CNT_WIDTH-1:0]  dec_rd,
    input  logic                      dec_halt,
    input  logic                      wb_valid,
    input  logic [ROB_SIZE_WIDTH-1:0] wb_id,
    input  logic [XLEN-1:0]           wb_val,
    input  logic                      wb_mispredict,
    input  logic [XLEN-1:0]           wb_pc,
    output logic                      rob_full,
    output logic                      rob_ready,
    output logic [REG_CNT_WIDTH-1:0]  rob_rd,
    output logic [XLEN-1:0]           rob_val,
    output logic [ROB_SIZE_WIDTH-1:0] rob_head_id,
    output logic [ROB_SIZE_WIDTH-1:0] rob_tail_id,
    output logic                      flush,
    output logic [XLEN-1:0]           flush_pc,
    output logic                      halted
);

    localparam int ENTRIES = 1 << ROB_SIZE_WIDTH;
    localparam logic [ROB_SIZE_WIDTH:0] FULL_COUNT = {1'b1, {ROB_SIZE_WIDTH{1'b0}}};

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t state_reg, state_next;

    logic [ROB_SIZE_WIDTH-1:0] head_reg, tail_reg;
    logic [ROB_SIZE_WIDTH:0]   count_reg, count_next;
    logic                      halted_reg;
    logic                      rob_ready_reg;
    logic [REG_CNT_WIDTH-1:0]  rob_rd_reg;
    logic [XLEN-1:0]           rob_val_reg;
    logic                      flush_reg;
    logic [XLEN-1:0]           flush_pc_reg;

    // Per-entry status flags need reset; payload fields are only read once valid.
    logic [ENTRIES-1:0]        valid_reg, ready_reg, misp_reg, halt_reg;
    logic [REG_CNT_WIDTH-1:0]  rd_mem  [ENTRIES];
    logic [XLEN-1:0]           val_mem [ENTRIES];
    logic [XLEN-1:0]           pc_mem  [ENTRIES];

    logic               alloc_en, commit_en, wb_en, flush_clear;
    logic               head_done, head_misp, head_halt;
    logic [ENTRIES-1:0] alloc_sel, commit_sel, wb_sel;

    always_comb begin
        head_done = valid_reg[head_reg] && ready_reg[head_reg];
        head_misp = misp_reg[head_reg];
        head_halt = halt_reg[head_reg];
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_RUN;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_RUN:   if (commit_en && head_misp) state_next = ST_DRAIN;
            ST_DRAIN: state_next = ST_FLUSH;
            ST_FLUSH: state_next = ST_RUN;
            default:  state_next = ST_RUN;
        endcase
    end

    // Output / control decode
    always_comb begin
        rob_full    = (count_reg == FULL_COUNT) || (state_reg != ST_RUN) || halted_reg;
        alloc_en    = dec_ready && !stall && !rob_full;
        commit_en   = (state_reg == ST_RUN) && !halted_reg && head_done;
        wb_en       = wb_valid && (state_reg == ST_RUN);
        flush_clear = (state_reg == ST_FLUSH);
    end

    always_comb begin
        count_next = count_reg;
        case ({alloc_en, commit_en})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < ENTRIES; gi = gi + 1) begin : g_entry_sel
            assign alloc_sel[gi]  = alloc_en  && (tail_reg == ROB_SIZE_WIDTH'(gi));
            assign commit_sel[gi] = commit_en && (head_reg == ROB_SIZE_WIDTH'(gi));
            assign wb_sel[gi]     = wb_en && valid_reg[gi] && (wb_id == ROB_SIZE_WIDTH'(gi));
        end
    endgenerate

    // Allocation is applied last; it never targets the committing slot since a
    // full buffer blocks allocation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_reg <= '0;
            ready_reg <= '0;
        end else if (flush_clear) begin
            valid_reg <= '0;
            ready_reg <= '0;
        end else begin
            for (int i = 0; i < ENTRIES; i++) begin
                if (wb_sel[i])     ready_reg[i] <= 1'b1;
                if (commit_sel[i]) valid_reg[i] <= 1'b0;
                if (alloc_sel[i]) begin
                    valid_reg[i] <= 1'b1;
                    ready_reg[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < ENTRIES; i++) begin
            if (alloc_sel[i]) begin
                rd_mem[i]   <= dec_rd;
                halt_reg[i] <= dec_halt;
            end
            if (wb_sel[i]) begin
                val_mem[i]  <= wb_val;
                misp_reg[i] <= wb_mispredict;
                pc_mem[i]   <= wb_pc;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_reg      <= '0;
            tail_reg      <= '0;
            count_reg     <= '0;
            halted_reg    <= 1'b0;
            rob_ready_reg <= 1'b0;
            rob_rd_reg    <= '0;
            rob_val_reg   <= '0;
            flush_reg     <= 1'b0;
            flush_pc_reg  <= '0;
        end else if (flush_clear) begin
            head_reg      <= '0;
            tail_reg      <= '0;
            count_reg     <= '0;
            rob_ready_reg <= 1'b0;
            flush_reg     <= 1'b0;
        end else begin
            if (alloc_en)  tail_reg <= tail_reg + 1'b1;
            if (commit_en) head_reg <= head_reg + 1'b1;
            count_reg     <= count_next;
            rob_ready_reg <= commit_en;
            // Flush is raised one cycle after the mispredict commit so the
            // register file sees that write before the pipeline is cleared.
            flush_reg     <= (state_reg == ST_DRAIN);
            if (commit_en) begin
                rob_rd_reg  <= rd_mem[head_reg];
                rob_val_reg <= val_mem[head_reg];
                if (head_misp) flush_pc_reg <= pc_mem[head_reg];
                if (head_halt) halted_reg   <= 1'b1;
            end
        end
    end

    assign rob_ready   = rob_ready_reg;
    assign rob_rd      = rob_rd_reg;
    assign rob_val     = rob_val_reg;
    assign rob_head_id = head_reg;
    assign rob_tail_id = tail_reg;
    assign flush       = flush_reg;
    assign flush_pc    = flush_pc_reg;
    assign halted      = halted_reg;

endmodule
